tff_array: RTL



---
 rtl/tff_pkg.sv | 11 +
 rtl/tff_array_if.sv | 32 +++
 rtl/tff_cell.sv | 42 ++++
 rtl/tff_array.sv | 96 +++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared mode encoding for the toggle/counter bank
package tff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'b00;
    localparam mode_t MODE_UP     = 2'b01;
    localparam mode_t MODE_DOWN   = 2'b10;
    localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/tff_array_if.sv
// rtl/tff_array_if.sv - control/data bundle between a driver and the toggle bank
// Signals:
//   en    step enable for toggle/count modes
//   mode  TOGGLE / UP / DOWN / HOLD
//   t     per-bit toggle request (TOGGLE mode only)
//   load  synchronous parallel load strobe
//   d     parallel load data
//   q     registered cell outputs
//   tc    registered terminal-count flag
interface tff_array_if #(
    parameter int WIDTH = 8
);

    logic               en;
    tff_pkg::mode_t     mode;
    logic [WIDTH-1:0]   t;
    logic               load;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   q;
    logic               tc;

    modport master (
        output en, mode, t, load, d,
        input  q, tc
    );

    modport slave (
        input  en, mode, t, load, d,
        output q, tc
    );

endinterface

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single toggle cell with async reset and parallel load
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, forces q to rst_val
//   rst_val  value taken on reset
//   load     load strobe, wins over t
//   d        load data
//   t        toggle request (already gated by the bank)
//   q        registered output
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_array.sv
// rtl/tff_array.sv - WIDTH-bit toggle bank: per-bit toggle, up/down counter, hold
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (q = RST_VAL, tc = 0)
//   bus  slave side of tff_array_if (en, mode, t, load, d in; q, tc out)
// Parameters:
//   WIDTH    number of cells
//   RST_VAL  q value after reset
//   SAT      0: count modes wrap, 1: count modes pin at the boundary
module tff_array
    import tff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    tff_array_if.slave       bus
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] carry_up;
    logic [WIDTH-1:0] carry_dn;
    logic [WIDTH-1:0] tog;
    logic             all_ones;
    logic             all_zero;
    logic             tc_q;
    logic             tc_d;

    // Synchronous T-counter enables: bit i flips when every lower bit is
    // 1 (counting up) or 0 (counting down). Bit 0 always flips.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        if (i == 0) begin : g_lsb
            assign carry_up[i] = 1'b1;
            assign carry_dn[i] = 1'b1;
        end else begin : g_upper
            assign carry_up[i] = &q_w[i-1:0];
            assign carry_dn[i] = ~|q_w[i-1:0];
        end
    end

    assign all_ones = &q_w;
    assign all_zero = ~|q_w;

    always_comb begin
        tog  = '0;
        tc_d = tc_q;
        if (bus.load) begin
            tc_d = 1'b0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_TOGGLE: begin
                    tog  = bus.t;
                    tc_d = 1'b0;
                end
                MODE_UP: begin
                    // Saturating at the boundary simply suppresses all toggles.
                    tog  = (SAT && all_ones) ? '0 : carry_up;
                    tc_d = all_ones;
                end
                MODE_DOWN: begin
                    tog  = (SAT && all_zero) ? '0 : carry_dn;
                    tc_d = all_zero;
                end
                default: begin
                    tc_d = 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .load    (bus.load),
            .d       (bus.d[i]),
            .t       (tog[i]),
            .q       (q_w[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign bus.q  = q_w;
    assign bus.tc = tc_q;

endmodule
